irq_seq: RTL and testbench
==========================

# irq_seq

Interrupt and reset sequencer for the 6502 core. It owns the seven-cycle break sequence shared by reset, NMI, IRQ and BRK: it pushes PCH, PCL and P, fetches the vector, and sets the I flag. It sits beside the addressing-mode next-state FSM. It takes over the address/data-path select lines while busy and hands control back at the next opcode fetch.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock, rising-edge
- R  in  1  reset; asynchronous, active-high
- SYNC  in  1  opcode-fetch cycle from the next-state FSM
- BRK  in  1  decoder: BRK opcode executing (only asserted with SYNC=0)
- IRQ  in  1  level interrupt request, active-high
- I_FLAG  in  1  current P.I
- NMI  in  1  non-maskable request, rising-edge sensitive
- TAKE  out  1  force BRK (0x00) into IR instead of the fetched opcode
- SPH, SPL, SPP  out  1 each  one-hot: push PCH / push PCL / push P state
- SVL, SVH  out  1 each  one-hot: vector low / vector high fetch state
- WE  out  1  memory write strobe for the push states
- STK_DEC  out  1  decrement S this cycle
- P_B  out  1  B bit value for the pushed P
- SEI  out  1  set P.I this cycle
- VEC  out  2  vector select: 01=FFFA (NMI), 10=FFFC (reset), 11=FFFE (IRQ/BRK), 00=idle
- BUSY  out  1  sequence in progress (any of SPH..SVH)

## Operation
- States: IDLE, PCH, PCL, PSR, VLO, VHI. One state per clock. SPH/SPL/SPP/SVL/SVH are decoded from PCH/PCL/PSR/VLO/VHI.
- Source register src ∈ {RST, NMI, IRQ, BRK}. Priority: RST > NMI > IRQ > BRK.
- NMI edge detect: nmi_q <= NMI every clock; edge = NMI & ~nmi_q; edge sets nmi_pend.
- Pending condition: pend = nmi_pend | (IRQ & ~I_FLAG). IRQ is not latched; it is sampled only when SYNC=1.
- IDLE transitions:
  - rst_pend=1 -> PCH, src=RST.
  - Else SYNC & pend -> TAKE=1 (combinational, same cycle) -> PCH; src=NMI if nmi_pend, else IRQ.
  - Else BRK -> PCH, src=BRK.
  - Otherwise stay in IDLE.
- Unconditional path: PCH -> PCL -> PSR -> VLO -> VHI -> IDLE.
- Push states (PCH, PCL, PSR): STK_DEC=1. WE=1 unless src=RST; the reset sequence performs dummy stack reads only.
- P_B: 1 when src=BRK, else 0. Held for the whole sequence.
- VEC: loaded on the PSR->VLO transition, then driven through VLO and VHI. Vector address low byte = {5'b11111, VEC, SVH}.
  - src=RST -> 10.
  - Else nmi_pend or edge in that cycle -> 01 (hijack of IRQ/BRK), and nmi_pend is cleared.
  - Else -> 11.
- SEI=1 in VLO for all sources.
- NMI edges in VLO/VHI stay pending and are taken at the next SYNC.

## Timing
- R asserted: state=IDLE, rst_pend=1, nmi_pend=0, nmi_q=0, src=RST. All outputs 0, VEC=00.
- R released: the first CLK edge enters PCH. SVH is reached 4 cycles later. IDLE returns on the 6th edge.
- Interrupt latency: SYNC&pend cycle (TAKE=1), then 5 sequence cycles, then IDLE. The following opcode fetch comes from the vector.
- rst_pend clears on the IDLE->PCH edge.
- R mid-sequence aborts immediately (asynchronous). The reset sequence then runs from scratch after release.
- NMI edge and IRQ at the same SYNC: NMI taken, IRQ ignored. IRQ re-evaluates at the next SYNC, with I now set.
- NMI held high: one edge gives exactly one sequence.
- BRK and SYNC&pend in the same cycle: the interrupt wins and BRK is dropped.

## Configuration
- IRQ_SEQ_NMI_EN defined: NMI edge detector, nmi_pend, hijack and VEC=01 are present as described.
- Not defined: NMI input ignored, nmi_pend tied 0, VEC never 01, no hijack.

## Test plan
- Reset release: R 1->0 -> PCH,PCL,PSR with WE=0 and STK_DEC=1, then VLO (VEC=10, SEI=1), VHI, then IDLE on the 6th clock.
- IRQ=1, I_FLAG=0 at SYNC -> TAKE=1 that cycle. Pushes with WE=1, P_B=0, VEC=11, SEI in VLO.
- IRQ=1, I_FLAG=1 at SYNC -> TAKE=0, stays IDLE. BRK=1 -> sequence with P_B=1, VEC=11.
- NMI rising edge during the PCL of a BRK sequence -> VEC=01 in VLO/VHI, P_B=1, nmi_pend cleared, no second sequence.
- NMI edge in VHI, NMI held high -> exactly one NMI sequence at the next SYNC. Without IRQ_SEQ_NMI_EN -> none.
- R pulsed during PSR of an IRQ sequence -> outputs 0 immediately, then the full reset sequence with VEC=10.

Source files
------------

// File: rtl/irq_seq.sv
// Seven-cycle break sequencer shared by reset, NMI, IRQ and BRK: pushes PCH/PCL/P, fetches the vector, sets I.
// Optional NMI support is compiled in when IRQ_SEQ_NMI_EN is defined.
module irq_seq (
    input  logic       CLK,
    input  logic       R,
    input  logic       SYNC,
    input  logic       BRK,
    input  logic       IRQ,
    input  logic       I_FLAG,
    input  logic       NMI,
    output logic       TAKE,
    output logic       SPH,
    output logic       SPL,
    output logic       SPP,
    output logic       SVL,
    output logic       SVH,
    output logic       WE,
    output logic       STK_DEC,
    output logic       P_B,
    output logic       SEI,
    output logic [1:0] VEC,
    output logic       BUSY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PCH  = 3'd1;
    localparam logic [2:0] S_PCL  = 3'd2;
    localparam logic [2:0] S_PSR  = 3'd3;
    localparam logic [2:0] S_VLO  = 3'd4;
    localparam logic [2:0] S_VHI  = 3'd5;

    localparam logic [1:0] SRC_RST = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_IRQ = 2'd2;
    localparam logic [1:0] SRC_BRK = 2'd3;

    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_RST = 2'b10;
    localparam logic [1:0] VEC_IRQ = 2'b11;

    logic [2:0] state_q, state_d;
    logic [1:0] src_q, src_d;
    logic [1:0] vec_q, vec_d;
    logic       rst_pend_q, rst_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_edge;
    logic       pend;
    logic       take;
    logic       push;

`ifdef IRQ_SEQ_NMI_EN
    logic nmi_q;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            nmi_q <= 1'b0;
        end else begin
            nmi_q <= NMI;
        end
    end

    assign nmi_edge = NMI & ~nmi_q;
`else
    logic unused_nmi;

    assign unused_nmi = NMI;
    assign nmi_edge   = 1'b0;
`endif

    // IRQ is a level and only matters on an opcode-fetch cycle; NMI is remembered until serviced.
    assign pend = nmi_pend_q | (IRQ & ~I_FLAG);
    assign take = (state_q == S_IDLE) & ~rst_pend_q & SYNC & pend;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        vec_d      = vec_q;
        rst_pend_d = rst_pend_q;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        case (state_q)
            S_IDLE: begin
                if (rst_pend_q) begin
                    state_d    = S_PCH;
                    src_d      = SRC_RST;
                    rst_pend_d = 1'b0;
                end else if (take) begin
                    state_d = S_PCH;
                    src_d   = nmi_pend_q ? SRC_NMI : SRC_IRQ;
                end else if (BRK) begin
                    state_d = S_PCH;
                    src_d   = SRC_BRK;
                end
            end
            S_PCH: state_d = S_PCL;
            S_PCL: state_d = S_PSR;
            S_PSR: begin
                // Last chance for a late NMI to hijack an IRQ/BRK before the vector is fetched.
                state_d = S_VLO;
                if (src_q == SRC_RST) begin
                    vec_d = VEC_RST;
                end else if (nmi_pend_q | nmi_edge) begin
                    vec_d      = VEC_NMI;
                    nmi_pend_d = 1'b0;
                end else begin
                    vec_d = VEC_IRQ;
                end
            end
            S_VLO:   state_d = S_VHI;
            S_VHI:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_RST;
            vec_q      <= 2'b00;
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            vec_q      <= vec_d;
            rst_pend_q <= rst_pend_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign SPH     = (state_q == S_PCH);
    assign SPL     = (state_q == S_PCL);
    assign SPP     = (state_q == S_PSR);
    assign SVL     = (state_q == S_VLO);
    assign SVH     = (state_q == S_VHI);
    assign push    = SPH | SPL | SPP;
    assign BUSY    = push | SVL | SVH;
    assign TAKE    = take;
    assign STK_DEC = push;
    // Reset only performs dummy stack reads, so the write strobe stays low.
    assign WE      = push & (src_q != SRC_RST);
    assign P_B     = BUSY & (src_q == SRC_BRK);
    assign SEI     = SVL;
    assign VEC     = (SVL | SVH) ? vec_q : 2'b00;

endmodule

// File: tb/tb_irq_seq.sv
// Self-checking bench for irq_seq: directed test-plan scenarios followed by random stimulus,
// compared each cycle against a step-counter reference model. Honours IRQ_SEQ_NMI_EN.
module tb_irq_seq;

`ifdef IRQ_SEQ_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    localparam int SRC_RST = 0;
    localparam int SRC_NMI = 1;
    localparam int SRC_IRQ = 2;
    localparam int SRC_BRK = 3;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       SYNC = 1'b0;
    logic       BRK = 1'b0;
    logic       IRQ = 1'b0;
    logic       I_FLAG = 1'b0;
    logic       NMI = 1'b0;
    logic       TAKE, SPH, SPL, SPP, SVL, SVH, WE, STK_DEC, P_B, SEI, BUSY;
    logic [1:0] VEC;

    int checks = 0;
    int errors = 0;

    // Reference model: step -1 is idle, 0..4 walks the five sequence cycles.
    int mStep;
    int mSrc;
    bit mRstPend;
    bit mNmiPend;
    bit mNmiPrev;
    bit [1:0] mVec;

    irq_seq dut (
        .CLK(CLK), .R(R), .SYNC(SYNC), .BRK(BRK), .IRQ(IRQ), .I_FLAG(I_FLAG), .NMI(NMI),
        .TAKE(TAKE), .SPH(SPH), .SPL(SPL), .SPP(SPP), .SVL(SVL), .SVH(SVH), .WE(WE),
        .STK_DEC(STK_DEC), .P_B(P_B), .SEI(SEI), .VEC(VEC), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic modelReset();
        mStep    = -1;
        mSrc     = SRC_RST;
        mRstPend = 1'b1;
        mNmiPend = 1'b0;
        mNmiPrev = 1'b0;
        mVec     = 2'b00;
    endtask

    function automatic bit modelTake();
        return (mStep == -1) && !mRstPend && SYNC && (mNmiPend || (IRQ && !I_FLAG));
    endfunction

    task automatic modelAdvance();
        bit nmiEdge;
        bit accept;
        nmiEdge  = NMI_EN && NMI && !mNmiPrev;
        mNmiPrev = NMI_EN && NMI;
        accept   = modelTake();
        if (mStep == -1) begin
            if (mRstPend) begin
                mStep = 0; mSrc = SRC_RST; mRstPend = 1'b0;
            end else if (accept) begin
                mStep = 0; mSrc = mNmiPend ? SRC_NMI : SRC_IRQ;
            end else if (BRK) begin
                mStep = 0; mSrc = SRC_BRK;
            end
            if (nmiEdge) mNmiPend = 1'b1;
        end else begin
            if (mStep == 2) begin
                if (mSrc == SRC_RST) begin
                    mVec = 2'b10;
                    if (nmiEdge) mNmiPend = 1'b1;
                end else if (mNmiPend || nmiEdge) begin
                    mVec = 2'b01;
                    mNmiPend = 1'b0;
                end else begin
                    mVec = 2'b11;
                end
            end else if (nmiEdge) begin
                mNmiPend = 1'b1;
            end
            mStep = (mStep == 4) ? -1 : mStep + 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        bit busy, push;
        busy = (mStep >= 0);
        push = (mStep >= 0) && (mStep <= 2);
        checkOutput("TAKE", {7'd0, TAKE}, {7'd0, modelTake()});
        checkOutput("BUSY", {7'd0, BUSY}, {7'd0, busy});
        checkOutput("onehot", {3'd0, SPH, SPL, SPP, SVL, SVH},
                    {3'd0, mStep == 0, mStep == 1, mStep == 2, mStep == 3, mStep == 4});
        checkOutput("WE", {7'd0, WE}, {7'd0, push && (mSrc != SRC_RST)});
        checkOutput("STK_DEC", {7'd0, STK_DEC}, {7'd0, push});
        checkOutput("P_B", {7'd0, P_B}, {7'd0, busy && (mSrc == SRC_BRK)});
        checkOutput("SEI", {7'd0, SEI}, {7'd0, mStep == 3});
        checkOutput("VEC", {6'd0, VEC}, {6'd0, (mStep >= 3) ? mVec : 2'b00});
    endtask

    // One clock: drive inputs after the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic applyStimulus(input bit r, input bit sync, input bit brk, input bit irq,
                                 input bit iflag, input bit nmi);
        @(negedge CLK);
        R = r; SYNC = sync; BRK = brk; IRQ = irq; I_FLAG = iflag; NMI = nmi;
        if (r) modelReset();
        #1;
        checkAll();
        @(posedge CLK);
        if (!r) modelAdvance();
    endtask

    task automatic idleCycles(input int n, input bit nmi);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nmi);
    endtask

    initial begin
        bit rSync, rBrk, rIrq, rIflag, rNmi, rR;
        modelReset();
        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset release sequence");
        idleCycles(7, 1'b0);

        $display("[TB] unmasked IRQ");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(6, 1'b0);

        $display("[TB] masked IRQ then BRK with NMI edge in PCL");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] NMI edge in VHI held high");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(5, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] NMI and IRQ at the same SYNC, BRK collision");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idleCycles(5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] reset during PSR of an IRQ sequence");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(7, 1'b0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 600; i++) begin
            rSync  = ($urandom_range(0, 2) == 0);
            rBrk   = !rSync && ($urandom_range(0, 7) == 0);
            rIrq   = ($urandom_range(0, 3) == 0);
            rIflag = $urandom_range(0, 1) != 0;
            rNmi   = ($urandom_range(0, 4) == 0) ? !NMI : NMI;
            rR     = ($urandom_range(0, 99) == 0);
            applyStimulus(rR, rSync, rBrk, rIrq, rIflag, rNmi);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
